// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester arbiter and the register bank it fronts.
// Holds the bus FSM encoding and the default bus widths.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [2:0] PPROT_DEFAULT  = 3'b000;
    localparam int         DEF_ADDR_WIDTH = 3;
    localparam int         DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last winner,
// so every active requester is reached within NUM_REQ grants.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_grant_i) + k) % NUM_REQ;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IDX_W'(idx);
                gnt_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB slave between NUM_REQ requesters: round-robin accept, SETUP/ACCESS
// sequencing with an optional pready timeout, and a one-cycle response pulse.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_slverr,
    output logic [ADDR_WIDTH-1:0]          paddr,
    output logic                           pwrite,
    output logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [2:0]                     pprot,
    output logic                           psel,
    output logic                           penable,
    input  logic [DATA_WIDTH-1:0]          prdata,
    input  logic                           pready,
    input  logic                           pslverr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
    logic                   cmd_write_q, cmd_write_d;
    logic [DATA_WIDTH-1:0]  cmd_wdata_q, cmd_wdata_d;
    logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_slverr_q, rsp_slverr_d;

    logic [NUM_REQ-1:0]     gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_valid;
    logic                   tmo_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx),
        .gnt_valid_o  (gnt_valid)
    );

    // The counter holds the number of ACCESS cycles already spent without pready.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_write_d  = cmd_write_q;
        cmd_wdata_d  = cmd_wdata_q;
        tmo_cnt_d    = tmo_cnt_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    cmd_addr_d   = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_write_d  = req_write[gnt_idx];
                    cmd_wdata_d  = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    last_grant_d = gnt_idx;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                tmo_cnt_d = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready takes priority over a timeout landing in the same cycle.
                if (pready) begin
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_rdata_d  = cmd_write_q ? '0 : prdata;
                    rsp_slverr_d = pslverr;
                    state_d      = ST_IDLE;
                end else if (tmo_hit) begin
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_rdata_d  = '0;
                    rsp_slverr_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            cmd_addr_q   <= '0;
            cmd_write_q  <= 1'b0;
            cmd_wdata_q  <= '0;
            tmo_cnt_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_write_q  <= cmd_write_d;
            cmd_wdata_q  <= cmd_wdata_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) ? gnt : '0;
    assign psel       = (state_q != ST_IDLE);
    assign penable    = (state_q == ST_ACCESS);
    assign paddr      = cmd_addr_q;
    assign pwrite     = cmd_write_q;
    assign pwdata     = cmd_wdata_q;
    assign pstrb      = '1;
    assign pprot      = PPROT_DEFAULT;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: two queued requesters, a small APB slave model with
// configurable wait/hang/error behaviour, and a response scoreboard.
module tb_apb_req_arbiter;

  localparam int NR = 2;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TMO = 15;
  localparam int EW = 12;  // {idx[2:0], slverr, rdata[7:0]}
  localparam int CW = 12;  // {write, addr[2:0], wdata[7:0]}

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_slverr;
  logic [AW-1:0]    paddr;
  logic             pwrite;
  logic [DW-1:0]    pwdata;
  logic [DW/8-1:0]  pstrb;
  logic [2:0]       pprot;
  logic             psel;
  logic             penable;
  logic [DW-1:0]    prdata;
  logic             pready;
  logic             pslverr;

  apb_req_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pprot      (pprot),
    .psel       (psel),
    .penable    (penable),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- APB slave model ----------------
  int         slv_wait = 0;
  bit         slv_hang = 1'b0;
  bit         slv_err = 1'b0;
  logic [7:0] slv_mem [8] = '{default: 8'h00};
  int         acc_cnt = 0;

  assign pready  = psel && penable && !slv_hang && (acc_cnt >= slv_wait);
  assign pslverr = pready && slv_err;
  assign prdata  = slv_mem[paddr];

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (psel && penable && pready && pwrite && !slv_err) slv_mem[paddr] <= pwdata;
  end

  // ---------------- requester drivers ----------------
  logic [CW-1:0] cq0[$];
  logic [CW-1:0] cq1[$];

  always begin : driver
    logic [NR-1:0] tk;
    logic [CW-1:0] c;
    @(negedge clk);
    tk = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (tk[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && ((i == 0) ? cq0.size() : cq1.size()) != 0) begin
        c = (i == 0) ? cq0.pop_front() : cq1.pop_front();
        req_write[i]          = c[11];
        req_addr[i*AW +: AW]  = c[10:8];
        req_wdata[i*DW +: DW] = c[7:0];
        req_valid[i]          = 1'b1;
      end
    end
  end

  task automatic push_cmd(input int r, input bit w, input int a, input int d);
    logic [CW-1:0] c;
    c = {w, 3'(a), 8'(d)};
    if (r == 0) cq0.push_back(c);
    else cq1.push_back(c);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] exp_q[$];
  logic [7:0]    ref_mem [8] = '{default: 8'h00};
  bit            chk_alt = 1'b0;
  bit            post_rst = 1'b0;
  bit            prev_alt = 1'b0;
  int            last_acc_idx = 0;
  int            last_acc_cyc = 0;
  int            cyc = 0;
  int            run = 0;
  logic          prev_psel = 1'b0;
  logic          prev_penable = 1'b0;
  logic [AW-1:0] prev_paddr = '0;

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    logic          w;
    logic [2:0]    a;
    logic [7:0]    d;
    logic [7:0]    e_dat;
    logic          e_err;
    int            exp_len;
    cyc++;
    if (rst) begin
      exp_q.delete();
      post_rst     = 1'b1;
      prev_alt     = 1'b0;
      prev_psel    = 1'b0;
      prev_penable = 1'b0;
      run          = 0;
    end else begin
      if (|req_ready) begin
        chk("ready_onehot", 32'($countones(req_ready)), 1);
        chk("ready_needs_valid", 32'(req_ready & ~req_valid), 0);
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          w = req_write[i];
          a = req_addr[i*AW +: AW];
          d = req_wdata[i*DW +: DW];
          if (slv_hang) begin
            e_err = 1'b1;
            e_dat = 8'h00;
          end else begin
            e_err = slv_err;
            e_dat = w ? 8'h00 : ref_mem[a];
            if (w && !slv_err) ref_mem[a] = d;
          end
          exp_q.push_back({3'(i), e_err, e_dat});
          if (post_rst) chk("first_grant_after_rst", i, 0);
          if (chk_alt) begin
            chk("rr_alternate", i, (last_acc_idx + 1) % NR);
            if (prev_alt) chk("xfer_gap", cyc - last_acc_cyc, 3);
          end
          post_rst     = 1'b0;
          prev_alt     = chk_alt;
          last_acc_idx = i;
          last_acc_cyc = cyc;
        end
      end
      if (penable && !prev_penable)
        chk("setup_then_access", {31'd0, prev_psel && !prev_penable && psel}, 1);
      if (penable && prev_penable)
        chk("paddr_stable", 32'(paddr), 32'(prev_paddr));
      if (penable) run++;
      else if (prev_penable) begin
        exp_len = slv_hang ? TMO : slv_wait + 1;
        chk("access_len", run, exp_len);
        run = 0;
      end
      if (|rsp_valid) begin
        chk("rsp_onehot", 32'($countones(rsp_valid)), 1);
        chk("rsp_after_access", {31'd0, prev_penable && !penable}, 1);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_owner", 32'(rsp_valid), 32'(1 << e[11:9]));
          chk("rsp_slverr", {31'd0, rsp_slverr}, {31'd0, e[8]});
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
        end
      end
      prev_psel    = psel;
      prev_penable = penable;
      prev_paddr   = paddr;
    end
  end

  task automatic wait_drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (cq0.size() == 0 && cq1.size() == 0 && req_valid == '0 &&
          exp_q.size() == 0 && !psel && rsp_valid == '0) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, done}, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_psel", {31'd0, psel}, 0);
    chk("rst_penable", {31'd0, penable}, 0);
    chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwrite", {31'd0, pwrite}, 0);
    chk("rst_pwdata", 32'(pwdata), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_slverr", {31'd0, rsp_slverr}, 0);
    chk("pstrb_all_ones", 32'(pstrb), 1);
    chk("pprot_zero", 32'(pprot), 0);
    rst = 1'b0;

    // single write then read-back
    push_cmd(0, 1'b1, 3, 8'hA5);
    push_cmd(0, 1'b0, 3, 0);
    wait_drain("drain_wr_rd", 60);

    // contention: both requesters continuously valid
    chk_alt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_cmd(0, k < 2, k, $urandom_range(255));
      push_cmd(1, k < 2, 4 + k, $urandom_range(255));
    end
    wait_drain("drain_contention", 100);
    chk_alt = 1'b0;

    // wait states
    push_cmd(0, 1'b1, 5, 8'h3C);
    wait_drain("drain_wr5", 40);
    slv_wait = 4;
    push_cmd(1, 1'b0, 5, 0);
    wait_drain("drain_wait", 60);
    slv_wait = 0;

    // timeout then normal service
    slv_hang = 1'b1;
    push_cmd(0, 1'b0, 2, 0);
    wait_drain("drain_timeout", 100);
    slv_hang = 1'b0;
    push_cmd(1, 1'b0, 5, 0);
    wait_drain("drain_after_tmo", 40);

    // slave error on write, then read the untouched location
    slv_err = 1'b1;
    push_cmd(1, 1'b1, 6, 8'h77);
    wait_drain("drain_slverr", 40);
    slv_err = 1'b0;
    push_cmd(0, 1'b0, 6, 0);
    wait_drain("drain_after_err", 40);

    // reset in the middle of an ACCESS wait
    slv_hang = 1'b1;
    push_cmd(0, 1'b0, 1, 0);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (penable) seen = 1'b1;
    end
    chk("reach_access", {31'd0, seen}, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_psel", {31'd0, psel}, 0);
    chk("rst_async_penable", {31'd0, penable}, 0);
    slv_hang = 1'b0;
    push_cmd(0, 1'b0, 0, 0);
    push_cmd(1, 1'b0, 7, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 0);
    end
    rst = 1'b0;
    wait_drain("drain_after_rst", 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
